// File: rtl/rv_fifo_interface.sv
// rv_fifo_interface
// Ready-valid bus interface with one FIFO per direction.
//   Write path (bus -> device): the bus pushes beats through WRITE_VALID_I and
//   WRITE_READY_O. The device sees the head entry on DATA_O/UPDATE_O and
//   consumes it with ACK_I.
//   Read path (device -> bus): the device pushes DATA_I with CHANGE_I, or the
//   FIFO takes an on-demand sample when the bus polls an empty FIFO. The bus
//   pops the head through READ_VALID_O/READ_READY_I, and READ_O pulses one
//   cycle after every bus read.
// Ports:
//   CLK_I, RST_NI                   clock, asynchronous active-low reset
//   READ_READY_I/READ_VALID_O/READ_DATA_O      bus read channel
//   WRITE_READY_O/WRITE_VALID_I/WRITE_DATA_I   bus write channel
//   READ_ENABLE_I, WRITE_ENABLE_I   on-demand sampling / bus write enables
//   UPDATE_O, DATA_O, ACK_I         device side of the write FIFO
//   CHANGE_I, DATA_I                device side of the read FIFO
//   READ_O                          registered pulse after each bus read
//   OVERFLOW_O, CLEAR_I             sticky dropped-push flag and its clear
//   WRITE_LEVEL_O, READ_LEVEL_O     FIFO occupancy
module rv_fifo_interface #(
    parameter int WRITE_WIDTH = 8,
    parameter int READ_WIDTH  = 8,
    parameter int WRITE_DEPTH = 4,
    parameter int READ_DEPTH  = 4
) (
    input  logic                               CLK_I,
    input  logic                               RST_NI,
    input  logic                               READ_READY_I,
    output logic                               READ_VALID_O,
    output logic [READ_WIDTH-1:0]              READ_DATA_O,
    output logic                               WRITE_READY_O,
    input  logic                               WRITE_VALID_I,
    input  logic [WRITE_WIDTH-1:0]             WRITE_DATA_I,
    input  logic                               READ_ENABLE_I,
    input  logic                               WRITE_ENABLE_I,
    output logic                               UPDATE_O,
    output logic [WRITE_WIDTH-1:0]             DATA_O,
    input  logic                               ACK_I,
    input  logic                               CHANGE_I,
    input  logic [READ_WIDTH-1:0]              DATA_I,
    output logic                               READ_O,
    output logic                               OVERFLOW_O,
    input  logic                               CLEAR_I,
    output logic [$clog2(WRITE_DEPTH+1)-1:0]   WRITE_LEVEL_O,
    output logic [$clog2(READ_DEPTH+1)-1:0]    READ_LEVEL_O
);

    localparam int WAW = $clog2(WRITE_DEPTH);
    localparam int WLW = $clog2(WRITE_DEPTH + 1);
    localparam int RAW = $clog2(READ_DEPTH);
    localparam int RLW = $clog2(READ_DEPTH + 1);

    localparam logic [WLW-1:0] WR_FULL   = WLW'(WRITE_DEPTH);
    localparam logic [WLW-1:0] WR_LONE   = WLW'(1);
    localparam logic [WAW-1:0] WR_PONE   = WAW'(1);
    localparam logic [RLW-1:0] RD_FULL   = RLW'(READ_DEPTH);
    localparam logic [RLW-1:0] RD_LONE   = RLW'(1);
    localparam logic [RAW-1:0] RD_PONE   = RAW'(1);

    // Storage (no reset: contents are don't-care until written)
    logic [WRITE_WIDTH-1:0] wr_mem_q [WRITE_DEPTH];
    logic [READ_WIDTH-1:0]  rd_mem_q [READ_DEPTH];

    // Pointers, levels and status flops
    logic [WAW-1:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    logic [WLW-1:0] wr_level_q, wr_level_d;
    logic [RAW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [RLW-1:0] rd_level_q, rd_level_d;
    logic           read_o_q, read_o_d;
    logic           overflow_q, overflow_d;

    // Handshake decodes
    logic wr_ready_s, wr_push_s, wr_pop_s, update_s;
    logic rd_valid_s, rd_req_s, rd_push_s, rd_pop_s, rd_full_s, ovf_set_s;

    assign wr_ready_s = WRITE_ENABLE_I && (wr_level_q != WR_FULL);
    assign update_s   = (wr_level_q != {WLW{1'b0}});
    assign wr_push_s  = WRITE_VALID_I && wr_ready_s;
    assign wr_pop_s   = update_s && ACK_I;

    assign rd_valid_s = (rd_level_q != {RLW{1'b0}});
    assign rd_full_s  = (rd_level_q == RD_FULL);
    assign rd_pop_s   = rd_valid_s && READ_READY_I;
    // Device push has priority; otherwise an empty FIFO is sampled once when polled.
    assign rd_req_s   = CHANGE_I ||
                        (READ_ENABLE_I && READ_READY_I && (rd_level_q == {RLW{1'b0}}));
    // When full, a push only fits if the head leaves in the same cycle.
    assign rd_push_s  = rd_req_s && (!rd_full_s || rd_pop_s);
    assign ovf_set_s  = rd_req_s && rd_full_s && !rd_pop_s;

    // Next-state computation for pointers, levels, READ_O pulse and overflow flag
    always_comb begin
        wr_wptr_d  = wr_wptr_q;
        wr_rptr_d  = wr_rptr_q;
        wr_level_d = wr_level_q;
        rd_wptr_d  = rd_wptr_q;
        rd_rptr_d  = rd_rptr_q;
        rd_level_d = rd_level_q;
        read_o_d   = rd_pop_s;
        overflow_d = overflow_q;

        if (wr_push_s) begin
            wr_wptr_d = wr_wptr_q + WR_PONE;
        end else begin
            wr_wptr_d = wr_wptr_q;
        end
        if (wr_pop_s) begin
            wr_rptr_d = wr_rptr_q + WR_PONE;
        end else begin
            wr_rptr_d = wr_rptr_q;
        end
        case ({wr_push_s, wr_pop_s})
            2'b10:   wr_level_d = wr_level_q + WR_LONE;
            2'b01:   wr_level_d = wr_level_q - WR_LONE;
            default: wr_level_d = wr_level_q;
        endcase

        if (rd_push_s) begin
            rd_wptr_d = rd_wptr_q + RD_PONE;
        end else begin
            rd_wptr_d = rd_wptr_q;
        end
        if (rd_pop_s) begin
            rd_rptr_d = rd_rptr_q + RD_PONE;
        end else begin
            rd_rptr_d = rd_rptr_q;
        end
        case ({rd_push_s, rd_pop_s})
            2'b10:   rd_level_d = rd_level_q + RD_LONE;
            2'b01:   rd_level_d = rd_level_q - RD_LONE;
            default: rd_level_d = rd_level_q;
        endcase

        // A new overflow wins over a clear in the same cycle.
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (CLEAR_I) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            wr_wptr_q  <= {WAW{1'b0}};
            wr_rptr_q  <= {WAW{1'b0}};
            wr_level_q <= {WLW{1'b0}};
            rd_wptr_q  <= {RAW{1'b0}};
            rd_rptr_q  <= {RAW{1'b0}};
            rd_level_q <= {RLW{1'b0}};
            read_o_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_wptr_q  <= wr_wptr_d;
            wr_rptr_q  <= wr_rptr_d;
            wr_level_q <= wr_level_d;
            rd_wptr_q  <= rd_wptr_d;
            rd_rptr_q  <= rd_rptr_d;
            rd_level_q <= rd_level_d;
            read_o_q   <= read_o_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage writes; a full-FIFO push with pop reuses the slot being vacated
    always_ff @(posedge CLK_I) begin
        if (wr_push_s) begin
            wr_mem_q[wr_wptr_q] <= WRITE_DATA_I;
        end
        if (rd_push_s) begin
            rd_mem_q[rd_wptr_q] <= DATA_I;
        end
    end

    assign WRITE_READY_O = wr_ready_s;
    assign UPDATE_O      = update_s;
    assign DATA_O        = wr_mem_q[wr_rptr_q];
    assign READ_VALID_O  = rd_valid_s;
    assign READ_DATA_O   = rd_mem_q[rd_rptr_q];
    assign READ_O        = read_o_q;
    assign OVERFLOW_O    = overflow_q;
    assign WRITE_LEVEL_O = wr_level_q;
    assign READ_LEVEL_O  = rd_level_q;

endmodule

// File: tb/tb_rv_fifo_interface.sv
// tb_rv_fifo_interface
// Directed scenarios followed by random traffic, every cycle compared against
// a queue-based reference model of both FIFOs.
`timescale 1ns/1ps
module tb_rv_fifo_interface;

    localparam int WD = 4;
    localparam int RD = 4;

    logic       clk;
    logic       RST_NI;
    logic       READ_READY_I;
    logic       READ_VALID_O;
    logic [7:0] READ_DATA_O;
    logic       WRITE_READY_O;
    logic       WRITE_VALID_I;
    logic [7:0] WRITE_DATA_I;
    logic       READ_ENABLE_I;
    logic       WRITE_ENABLE_I;
    logic       UPDATE_O;
    logic [7:0] DATA_O;
    logic       ACK_I;
    logic       CHANGE_I;
    logic [7:0] DATA_I;
    logic       READ_O;
    logic       OVERFLOW_O;
    logic       CLEAR_I;
    logic [2:0] WRITE_LEVEL_O;
    logic [2:0] READ_LEVEL_O;

    rv_fifo_interface #(
        .WRITE_WIDTH(8), .READ_WIDTH(8), .WRITE_DEPTH(WD), .READ_DEPTH(RD)
    ) dut (
        .CLK_I(clk), .RST_NI(RST_NI),
        .READ_READY_I(READ_READY_I), .READ_VALID_O(READ_VALID_O), .READ_DATA_O(READ_DATA_O),
        .WRITE_READY_O(WRITE_READY_O), .WRITE_VALID_I(WRITE_VALID_I), .WRITE_DATA_I(WRITE_DATA_I),
        .READ_ENABLE_I(READ_ENABLE_I), .WRITE_ENABLE_I(WRITE_ENABLE_I),
        .UPDATE_O(UPDATE_O), .DATA_O(DATA_O), .ACK_I(ACK_I),
        .CHANGE_I(CHANGE_I), .DATA_I(DATA_I), .READ_O(READ_O),
        .OVERFLOW_O(OVERFLOW_O), .CLEAR_I(CLEAR_I),
        .WRITE_LEVEL_O(WRITE_LEVEL_O), .READ_LEVEL_O(READ_LEVEL_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain queues plus the two flags
    logic [7:0] wq[$];
    logic [7:0] rq[$];
    bit         m_ovf    = 1'b0;
    bit         m_read_o = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        WRITE_VALID_I  = 1'b0;
        WRITE_DATA_I   = 8'h00;
        ACK_I          = 1'b0;
        CHANGE_I       = 1'b0;
        DATA_I         = 8'h00;
        READ_READY_I   = 1'b0;
        READ_ENABLE_I  = 1'b0;
        CLEAR_I        = 1'b0;
        WRITE_ENABLE_I = 1'b1;
    endtask

    task automatic check_outputs();
        check_val("wr_ready", WRITE_READY_O, WRITE_ENABLE_I && (wq.size() != WD));
        check_val("update", UPDATE_O, wq.size() != 0);
        if (wq.size() != 0) check_val("data_o", DATA_O, wq[0]);
        check_val("wr_level", WRITE_LEVEL_O, wq.size());
        check_val("rd_valid", READ_VALID_O, rq.size() != 0);
        if (rq.size() != 0) check_val("rd_data", READ_DATA_O, rq[0]);
        check_val("rd_level", READ_LEVEL_O, rq.size());
        check_val("overflow", OVERFLOW_O, m_ovf);
        check_val("read_o", READ_O, m_read_o);
    endtask

    // Called at posedge+1 with inputs set: check, advance the model, clock once.
    task automatic step();
        int wsz;
        int rsz;
        bit wpush, wpop, rreq, rpop, oset;
        #1;
        check_outputs();
        wsz   = wq.size();
        rsz   = rq.size();
        wpush = WRITE_VALID_I && WRITE_ENABLE_I && (wsz != WD);
        wpop  = (wsz != 0) && ACK_I;
        rreq  = CHANGE_I || (READ_ENABLE_I && READ_READY_I && (rsz == 0));
        rpop  = (rsz != 0) && READ_READY_I;
        oset  = 1'b0;
        if (wpop) void'(wq.pop_front());
        if (wpush) wq.push_back(WRITE_DATA_I);
        if (rpop) void'(rq.pop_front());
        if (rreq) begin
            if (rsz < RD || rpop) rq.push_back(DATA_I);
            else oset = 1'b1;
        end
        if (oset) m_ovf = 1'b1;
        else if (CLEAR_I) m_ovf = 1'b0;
        m_read_o = rpop;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: assert reset mid-cycle, check before any edge.
    task automatic apply_reset();
        #2;
        RST_NI = 1'b0;
        #1;
        wq.delete();
        rq.delete();
        m_ovf    = 1'b0;
        m_read_o = 1'b0;
        check_val("rst_wr_level", WRITE_LEVEL_O, 0);
        check_val("rst_rd_level", READ_LEVEL_O, 0);
        check_val("rst_rd_valid", READ_VALID_O, 0);
        check_val("rst_update", UPDATE_O, 0);
        check_val("rst_overflow", OVERFLOW_O, 0);
        check_val("rst_read_o", READ_O, 0);
        check_val("rst_wr_ready", WRITE_READY_O, WRITE_ENABLE_I);
        @(posedge clk);
        #1;
        RST_NI = 1'b1;
    endtask

    initial begin
        logic [7:0] wdat [6];
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
        wdat[3] = 8'h44; wdat[4] = 8'h55; wdat[5] = 8'h66;

        RST_NI = 1'b0;
        idle();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        RST_NI = 1'b1;

        // Write fill, fifth beat refused
        for (int i = 0; i < 5; i++) begin
            WRITE_VALID_I = 1'b1;
            WRITE_DATA_I  = wdat[i];
            step();
        end
        check_val("fill_level", WRITE_LEVEL_O, 4);
        check_val("fill_ready", WRITE_READY_O, 0);
        check_val("fill_head", DATA_O, 8'h11);

        // Drain with wrap while pushing 0x55, 0x66
        ACK_I = 1'b1;
        WRITE_VALID_I = 1'b1; WRITE_DATA_I = 8'h55; step();
        WRITE_VALID_I = 1'b1; WRITE_DATA_I = 8'h55; step();
        WRITE_VALID_I = 1'b1; WRITE_DATA_I = 8'h66; step();
        WRITE_VALID_I = 1'b0; step();
        ACK_I = 1'b0;
        check_val("wrap_level", WRITE_LEVEL_O, 2);
        check_val("wrap_head", DATA_O, 8'h55);
        ACK_I = 1'b1;
        step();
        step();
        ACK_I = 1'b0;

        // Read stream 0xA0..0xA3, bus ready from cycle 3
        for (int i = 0; i < 10; i++) begin
            CHANGE_I     = (i < 4);
            DATA_I       = 8'hA0 + 8'(i);
            READ_READY_I = (i >= 3);
            step();
        end
        idle();
        check_val("stream_level", READ_LEVEL_O, 0);

        // Overflow and clear
        for (int i = 0; i < 5; i++) begin
            CHANGE_I = 1'b1;
            DATA_I   = 8'hB0 + 8'(i);
            step();
        end
        CHANGE_I = 1'b0;
        check_val("ovf_level", READ_LEVEL_O, 4);
        check_val("ovf_flag", OVERFLOW_O, 1);
        CLEAR_I = 1'b1;
        step();
        CLEAR_I = 1'b0;
        check_val("ovf_cleared", OVERFLOW_O, 0);
        READ_READY_I = 1'b1;
        for (int i = 0; i < 5; i++) step();
        idle();
        step();

        // On-demand poll
        READ_ENABLE_I = 1'b1;
        READ_READY_I  = 1'b1;
        DATA_I        = 8'h5C;
        step();
        check_val("poll_valid", READ_VALID_O, 1);
        check_val("poll_data", READ_DATA_O, 8'h5C);
        READ_ENABLE_I = 1'b0;
        step();
        check_val("poll_read_o", READ_O, 1);
        idle();
        step();

        // Async reset with two entries in each FIFO
        for (int i = 0; i < 2; i++) begin
            WRITE_VALID_I = 1'b1;
            WRITE_DATA_I  = 8'hC0 + 8'(i);
            CHANGE_I      = 1'b1;
            DATA_I        = 8'hD0 + 8'(i);
            step();
        end
        idle();
        check_val("pre_rst_wr_level", WRITE_LEVEL_O, 2);
        check_val("pre_rst_rd_level", READ_LEVEL_O, 2);
        apply_reset();
        step();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            WRITE_VALID_I  = ($urandom_range(0, 1) == 0);
            WRITE_DATA_I   = 8'($urandom);
            WRITE_ENABLE_I = ($urandom_range(0, 4) != 0);
            ACK_I          = ($urandom_range(0, 4) < 2);
            CHANGE_I       = ($urandom_range(0, 9) < 3);
            DATA_I         = 8'($urandom);
            READ_READY_I   = ($urandom_range(0, 1) == 0);
            READ_ENABLE_I  = ($urandom_range(0, 9) < 3);
            CLEAR_I        = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) apply_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_fifo_interface.md
Name: rv_fifo_interface

Overview:
- Parametrised successor to the single-register ready-valid bus interface.
- Places an independent FIFO in each direction: bus-to-device (write) and device-to-bus (read).
- Adds configurable depth, fill-level reporting, overflow detection and an explicit device-side pop handshake.
- Sits between the system ready-valid bus and a device register file or trace-buffer control logic.

Parameters:
- WRITE_WIDTH, 8, width of bus write data and device output data.
- READ_WIDTH, 8, width of device input data and bus read data.
- WRITE_DEPTH, 4, write FIFO entries; power of two, >= 2.
- READ_DEPTH, 4, read FIFO entries; power of two, >= 2.

Ports:
- CLK_I  in  1  clock; all logic on the rising edge.
- RST_NI  in  1  reset, asynchronous, active-low.
- READ_READY_I  in  1  bus is ready to accept read data.
- READ_VALID_O  out  1  read FIFO head is valid.
- READ_DATA_O  out  READ_WIDTH  read FIFO head entry.
- WRITE_READY_O  out  1  write FIFO can accept a beat.
- WRITE_VALID_I  in  1  bus write beat is valid.
- WRITE_DATA_I  in  WRITE_WIDTH  bus write data.
- READ_ENABLE_I  in  1  enables on-demand sampling of DATA_I.
- WRITE_ENABLE_I  in  1  enables bus writes.
- UPDATE_O  out  1  write FIFO non-empty; DATA_O is valid.
- DATA_O  out  WRITE_WIDTH  write FIFO head entry.
- ACK_I  in  1  device consumes DATA_O; ignored when UPDATE_O=0.
- CHANGE_I  in  1  push DATA_I into the read FIFO.
- DATA_I  in  READ_WIDTH  device data.
- READ_O  out  1  one-cycle pulse, registered one cycle after a bus read handshake.
- OVERFLOW_O  out  1  sticky: a device push was dropped.
- CLEAR_I  in  1  synchronous clear of OVERFLOW_O.
- WRITE_LEVEL_O  out  $clog2(WRITE_DEPTH+1)  write FIFO occupancy.
- READ_LEVEL_O  out  $clog2(READ_DEPTH+1)  read FIFO occupancy.

Behaviour:
- Reset (RST_NI=0, asynchronous):
  - Pointers and levels are 0.
  - READ_VALID_O, UPDATE_O, READ_O and OVERFLOW_O are 0.
  - WRITE_READY_O follows WRITE_ENABLE_I, since the FIFO is empty.
  - FIFO storage contents are don't-care.
  - Reset asserted mid-transfer discards all entries. No handshake completes in that cycle.
- Write path:
  - WRITE_READY_O = WRITE_ENABLE_I && (WRITE_LEVEL_O != WRITE_DEPTH), combinational.
  - Push when WRITE_VALID_I && WRITE_READY_O.
  - Pop when UPDATE_O && ACK_I.
  - Push into an empty FIFO makes UPDATE_O=1 and DATA_O=pushed data on the next cycle (1-cycle latency).
  - Simultaneous push and pop: level unchanged. Push and pop at the same time into an empty FIFO never occurs, because UPDATE_O=0.
  - With WRITE_ENABLE_I=0, already-queued entries still drain to the device.
- Read path push sources, in priority order:
  - (a) CHANGE_I=1 pushes DATA_I.
  - (b) Otherwise, if READ_ENABLE_I && READ_READY_I && READ_LEVEL_O==0, DATA_I is pushed once (on-demand sample). That sample appears on READ_VALID_O the next cycle.
  - At most one push per cycle.
- Read path pop:
  - Pop when READ_VALID_O && READ_READY_I.
  - READ_VALID_O = (READ_LEVEL_O != 0).
  - READ_O is asserted the cycle after each pop.
- Read FIFO full:
  - A push with no simultaneous pop is dropped, and OVERFLOW_O is set.
  - A push with a simultaneous pop is accepted; level stays at READ_DEPTH.
- OVERFLOW_O:
  - Stays set until CLEAR_I=1.
  - If CLEAR_I and a new overflow occur in the same cycle, OVERFLOW_O stays 1.
- Pointers:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Levels are separate counters updated by +1, -1 or 0. They never exceed DEPTH and never underflow.
- READ_DATA_O and DATA_O are read directly from storage at the head pointer, with no extra register stage. Data order is strictly FIFO.
- Levels are registered and reflect the state after the previous edge.

Test Plan:
- Write fill: WRITE_ENABLE_I=1, ACK_I=0, push 0x11,0x22,0x33,0x44 -> WRITE_LEVEL_O=4 and WRITE_READY_O=0. A fifth beat (0x55) is not accepted. DATA_O=0x11.
- Write drain with wrap: from the full state, ACK_I=1 for 4 cycles while pushing 0x55,0x66 -> DATA_O sequence is 0x11,0x22,0x33,0x44,0x55,0x66 and the level ends at 2.
- Read stream: CHANGE_I pulses with 0xA0..0xA3, READ_READY_I=1 from cycle 3 -> bus sees 0xA0..0xA3 in order. Each transfer is followed one cycle later by a READ_O pulse. READ_LEVEL_O returns to 0.
- Overflow: READ_DEPTH=4, five CHANGE_I pushes with READ_READY_I=0 -> level is 4, the fifth datum is dropped and OVERFLOW_O=1. A one-cycle CLEAR_I clears it.
- On-demand poll: empty read FIFO, READ_ENABLE_I=1, READ_READY_I=1, DATA_I=0x5C -> READ_VALID_O=1 with 0x5C on the next cycle, then READ_O the following cycle.
- Async reset: assert RST_NI=0 mid-cycle while both FIFOs hold 2 entries -> levels, READ_VALID_O, UPDATE_O and OVERFLOW_O go to 0 immediately, without waiting for a clock edge.
